ldtu_gain_mode_ctrl: RTL
========================

Name: ldtu_gain_mode_ctrl

Overview:
Sequences run-time changes of GAIN_SEL_MODE into the input-FIFO / gain-selection datapath so a change never lands inside an open gain-x1 window. Accepts mode requests from the configuration registers over a valid/ready handshake. Defers each change until the datapath is quiet, then applies it, flushes the FIFO read alignment and blanks the output while the selection window refills. Also counts gain-x10 to gain-x1 switch events for monitoring.

Parameters:
QUIET_LEN, 16, consecutive gain-x10 cycles required before a mode change is applied (2..255)
TIMEOUT, 1023, maximum WAIT_QUIET cycles before a forced apply (QUIET_LEN..1023)
SETTLE_LEN, 16, blanking cycles after apply; covers the 16-sample window (1..255)
DEFAULT_MODE, 2'b00, GAIN_SEL_MODE value at reset
CNT_W, 16, width of the switch-event counter

Ports:
CLK  in  1  LiTe-DTU clock
reset  in  1  asynchronous, active-high reset
mode_req  in  2  requested GAIN_SEL_MODE
mode_req_valid  in  1  request valid
mode_req_ready  out  1  controller can accept a request
mode_ack  out  1  one-cycle pulse: request completed
gain_flag  in  1  datapath gain bit (DATA_to_enc[12]); 1 = gain x1 selected
GAIN_SEL_MODE  out  2  mode driven to the datapath
fifo_flush  out  1  one-cycle pulse: re-align FIFO read pointers
out_blank  out  1  datapath output invalid (encoder ignores samples)
timeout_flag  out  1  sticky: at least one apply was forced by timeout
switch_cnt  out  CNT_W  number of gain_flag rising edges, saturating
cnt_clr  in  1  synchronous clear of switch_cnt and timeout_flag

Behaviour:
- Reset (asynchronous, active-high) values: state IDLE, GAIN_SEL_MODE=DEFAULT_MODE, mode_req_ready=1, mode_ack=0, fifo_flush=0, out_blank=0, timeout_flag=0, switch_cnt=0, all internal counters 0, pending=DEFAULT_MODE, gain_flag_d=0.
- The handshake fires when mode_req_valid & mode_req_ready. mode_req is captured into pending on that edge. mode_req_ready=1 only in IDLE. Valid while not ready is ignored and is not queued.
- IDLE:
  - Handshake with mode_req==GAIN_SEL_MODE: mode_ack pulses on the next cycle. State stays IDLE.
  - Handshake with mode_req!=GAIN_SEL_MODE: go to WAIT_QUIET. quiet_cnt=0, to_cnt=0.
- WAIT_QUIET:
  - Every cycle: to_cnt+1.
  - gain_flag=0: quiet_cnt+1. gain_flag=1: quiet_cnt=0.
  - quiet_cnt reaching QUIET_LEN-1 with gain_flag=0 goes to APPLY. This takes priority over timeout in the same cycle.
  - Otherwise, to_cnt reaching TIMEOUT-1 goes to APPLY and sets timeout_flag.
- APPLY (1 cycle): GAIN_SEL_MODE<=pending, fifo_flush=1, out_blank=1. Go to SETTLE with settle_cnt=0.
- SETTLE: out_blank=1, settle_cnt+1. At SETTLE_LEN-1, go to IDLE. out_blank drops and mode_ack pulses on the IDLE-entry cycle.
- Latency: a request with gain_flag held 0 gives mode_ack exactly QUIET_LEN+SETTLE_LEN+2 cycles after the handshake edge.
- GAIN_SEL_MODE changes only on the APPLY edge. It is never glitched.
- switch_cnt:
  - Increments when gain_flag & ~gain_flag_d, in every state.
  - Holds at all-ones (saturates).
  - cnt_clr has priority over an increment in the same cycle; it clears both switch_cnt and timeout_flag.
  - A timeout in the same cycle as cnt_clr leaves timeout_flag=1.
- Reset mid-operation (any state): all outputs return to reset values immediately. The pending request is dropped and no mode_ack is issued.

Test Plan:
- Reset, then request mode 2'b01 with gain_flag=0 held: ready drops, fifo_flush pulses at cycle 17 after handshake, GAIN_SEL_MODE=01 same edge, out_blank high 17 cycles, mode_ack at cycle 34, ready=1.
- Request 2'b00 while GAIN_SEL_MODE=00: mode_ack next cycle, no flush, no blank, state IDLE.
- Request 2'b11; toggle gain_flag 1 every 10 cycles: quiet never reached, apply at to_cnt=1022, timeout_flag=1. Then cnt_clr: timeout_flag=0.
- Request 2'b10; gain_flag=1 for 5 cycles then 0: apply 5+16 cycles after handshake. Second valid during WAIT_QUIET is ignored, and GAIN_SEL_MODE ends at 10.
- Drive 65540 gain_flag rising edges: switch_cnt=16'hFFFF. cnt_clr coincident with an edge: switch_cnt=0.
- Assert reset during SETTLE: GAIN_SEL_MODE=DEFAULT_MODE, out_blank=0, no mode_ack. A new request after release completes normally.

Source files
------------

// File: rtl/ldtu_gain_mode_ctrl.sv
// Purpose : sequences run-time GAIN_SEL_MODE changes into the input-FIFO / gain-selection datapath.
// Latency : with gain_flag held 0, mode_ack follows the handshake edge by QUIET_LEN+SETTLE_LEN+2 cycles.
// Backpr. : mode_req_ready is high only while idle; a valid seen while not ready is dropped, never queued.
//
// Ports:
//   CLK, reset            clock, asynchronous active-high reset
//   mode_req/_valid/_ready  mode-change request handshake from the configuration registers
//   mode_ack              one-cycle pulse when a request has fully completed
//   gain_flag             datapath gain bit, 1 = gain x1 selected
//   GAIN_SEL_MODE         mode driven into the datapath (changes only on the apply edge)
//   fifo_flush            one-cycle pulse to re-align the FIFO read pointers
//   out_blank             datapath output invalid while the selection window refills
//   timeout_flag          sticky: an apply was forced because the datapath never went quiet
//   switch_cnt            saturating count of gain_flag rising edges (x10 -> x1 switches)
//   cnt_clr               synchronous clear of switch_cnt and timeout_flag
module ldtu_gain_mode_ctrl #(
    parameter int unsigned QUIET_LEN    = 16,
    parameter int unsigned TIMEOUT      = 1023,
    parameter int unsigned SETTLE_LEN   = 16,
    parameter logic [1:0]  DEFAULT_MODE = 2'b00,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [1:0]       mode_req,
    input  logic             mode_req_valid,
    output logic             mode_req_ready,
    output logic             mode_ack,
    input  logic             gain_flag,
    output logic [1:0]       GAIN_SEL_MODE,
    output logic             fifo_flush,
    output logic             out_blank,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] switch_cnt,
    input  logic             cnt_clr
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_QUIET = 2'd1,
        APPLY      = 2'd2,
        SETTLE     = 2'd3
    } state_t;

    // Terminal counts, sized to the counters they are compared against.
    localparam logic [7:0] QUIET_LAST  = 8'(QUIET_LEN - 1);
    localparam logic [9:0] TO_LAST     = 10'(TIMEOUT - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_LEN - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] quiet_cnt;
    logic [7:0] quiet_nxt;
    logic [9:0] to_cnt;
    logic [9:0] to_nxt;
    logic [7:0] settle_cnt;
    logic [7:0] settle_nxt;
    logic [1:0] pending;
    logic       gain_flag_d;
    logic       handshake;
    logic       same_mode;
    logic       force_apply;
    logic       switch_evt;

    // Ready is withheld during the single idle cycle in which the completion
    // ack is still being generated, so a back-to-back same-mode request can
    // never merge its ack into the previous one.
    assign mode_req_ready = (state == IDLE) && !out_blank;
    assign handshake      = mode_req_valid && mode_req_ready;
    assign same_mode      = (mode_req == GAIN_SEL_MODE);
    assign switch_evt     = gain_flag && !gain_flag_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        quiet_nxt   = quiet_cnt;
        to_nxt      = to_cnt;
        settle_nxt  = settle_cnt;
        force_apply = 1'b0;

        case (state)
            IDLE: begin
                if (handshake && !same_mode) begin
                    state_nxt = WAIT_QUIET;
                    quiet_nxt = '0;
                    to_nxt    = '0;
                end
            end

            WAIT_QUIET: begin
                to_nxt    = to_cnt + 10'd1;
                quiet_nxt = gain_flag ? 8'd0 : (quiet_cnt + 8'd1);
                // A genuinely quiet datapath wins over the timeout when both
                // become true together, so timeout_flag only marks real forcing.
                if (!gain_flag && (quiet_cnt == QUIET_LAST)) begin
                    state_nxt = APPLY;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt   = APPLY;
                    force_apply = 1'b1;
                end
            end

            APPLY: begin
                state_nxt  = SETTLE;
                settle_nxt = '0;
            end

            SETTLE: begin
                settle_nxt = settle_cnt + 8'd1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            quiet_cnt  <= '0;
            to_cnt     <= '0;
            settle_cnt <= '0;
            pending    <= DEFAULT_MODE;
        end else begin
            state      <= state_nxt;
            quiet_cnt  <= quiet_nxt;
            to_cnt     <= to_nxt;
            settle_cnt <= settle_nxt;
            if (handshake) begin
                pending <= mode_req;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered datapath-facing outputs
    // ------------------------------------------------------------------
    // All outputs are registered from the state, so the mode, the flush
    // pulse and the start of blanking appear together on the edge that
    // leaves APPLY; GAIN_SEL_MODE therefore cannot glitch.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            GAIN_SEL_MODE <= DEFAULT_MODE;
            fifo_flush    <= 1'b0;
            out_blank     <= 1'b0;
            mode_ack      <= 1'b0;
        end else begin
            if (state == APPLY) begin
                GAIN_SEL_MODE <= pending;
            end
            fifo_flush <= (state == APPLY);
            out_blank  <= (state == APPLY) || (state == SETTLE);
            // Completion is the first idle cycle while blanking is still up:
            // blanking drops on the same edge that raises the ack.
            mode_ack   <= (handshake && same_mode) || ((state == IDLE) && out_blank);
        end
    end

    // ------------------------------------------------------------------
    // Monitoring: switch counter and timeout flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            gain_flag_d  <= 1'b0;
            switch_cnt   <= '0;
            timeout_flag <= 1'b0;
        end else begin
            gain_flag_d <= gain_flag;

            if (cnt_clr) begin
                switch_cnt <= '0;
            end else if (switch_evt && (switch_cnt != {CNT_W{1'b1}})) begin
                switch_cnt <= switch_cnt + 1'b1;
            end

            // A forced apply coinciding with a clear must not be lost.
            if (force_apply) begin
                timeout_flag <= 1'b1;
            end else if (cnt_clr) begin
                timeout_flag <= 1'b0;
            end
        end
    end

endmodule
